// File: rtl/rsa_pkg.sv
// Shared FSM encodings, default example key and Montgomery op cost for the RSA codec.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rsa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TOMONT,
    ST_SQR,
    ST_MUL,
    ST_FROMMONT,
    ST_DONE
  } state_e;

  // Default example key (textbook p=61, q=53 pair).
  localparam int DEF_N_BIT   = 12;
  localparam int DEF_N       = 3233;
  localparam int DEF_EXP_BIT = 12;
  localparam int DEF_E       = 17;
  localparam int DEF_D       = 2753;
  localparam int DEF_RMODN   = 863;
  localparam int DEF_R2MODN  = 1179;

  // One Montgomery product: N_BIT bit steps, one subtract, one hand-off cycle.
  function automatic int mm_lat(input int n_bit);
    return n_bit + 2;
  endfunction

  localparam int MM_LAT = mm_lat(DEF_N_BIT);

endpackage

// File: rtl/rsa_codec_mont_mul.sv
// Bit-serial radix-2 Montgomery multiplier: z = x*y*2^-N_BIT mod N, fully reduced.
// Latency: start sampled -> done pulse after N_BIT+1 edges (N_BIT steps + subtract).
// Backpressure: none; start while busy is ignored, done is a one-cycle pulse.
module mont_mul #(
  parameter int N_BIT = 12,
  parameter int N     = 3233
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_BIT-1:0] x,
  input  logic [N_BIT-1:0] y,
  output logic             done,
  output logic [N_BIT-1:0] z
);

  // Two guard bits: acc < 2N always, intermediate sum < 4N.
  localparam int AW = N_BIT + 2;
  localparam int CW = $clog2(N_BIT + 1);
  localparam logic [AW-1:0] N_W = AW'(N);

  logic [AW-1:0]    acc_q, acc_d;
  logic [N_BIT-1:0] xr_q, xr_d;
  logic [N_BIT-1:0] yr_q, yr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [N_BIT-1:0] z_q, z_d;

  // acc = (acc + ybit*x + q*N) / 2 with q chosen to make the sum even.
  function automatic logic [AW-1:0] mm_step(input logic [AW-1:0] acc,
                                            input logic [N_BIT-1:0] xv,
                                            input logic yb);
    logic [AW-1:0] t;
    t = acc + (yb ? {2'b00, xv} : {AW{1'b0}});
    if (t[0]) t = t + N_W;
    return t >> 1;
  endfunction

  // First bit step happens on the start edge so one op fits MM_LAT cycles.
  always_comb begin
    acc_d  = acc_q;
    xr_d   = xr_q;
    yr_d   = yr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    z_d    = z_q;
    if (!busy_q) begin
      if (start) begin
        acc_d  = mm_step({AW{1'b0}}, x, y[0]);
        xr_d   = x;
        yr_d   = y >> 1;
        cnt_d  = CW'(1);
        busy_d = 1'b1;
      end
    end else if (cnt_q < CW'(N_BIT)) begin
      acc_d = mm_step(acc_q, xr_q, yr_q[0]);
      yr_d  = yr_q >> 1;
      cnt_d = cnt_q + 1'b1;
    end else begin
      z_d    = (acc_q >= N_W) ? N_BIT'(acc_q - N_W) : N_BIT'(acc_q);
      done_d = 1'b1;
      busy_d = 1'b0;
    end
  end

  // State registers; reset abandons any product in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      xr_q   <= '0;
      yr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      z_q    <= '0;
    end else begin
      acc_q  <= acc_d;
      xr_q   <= xr_d;
      yr_q   <= yr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      z_q    <= z_d;
    end
  end

  assign done = done_q;
  assign z    = z_q;

endmodule

// File: rtl/rsa_codec.sv
// RSA engine: data_out = data_in^(E or D) mod N via left-to-right Montgomery exponentiation.
// Latency: 1 + MM_LAT*(2 + EXP_BIT + popcount(exp)) cycles; 2 cycles for an out-of-range operand.
// Backpressure: result held in DONE until out_ready; no new accept until back in IDLE.
module rsa_codec
  import rsa_pkg::*;
#(
  parameter int N_BIT   = DEF_N_BIT,
  parameter int N       = DEF_N,
  parameter int EXP_BIT = DEF_EXP_BIT,
  parameter int E       = DEF_E,
  parameter int D       = DEF_D,
  parameter int RMODN   = DEF_RMODN,
  parameter int R2MODN  = DEF_R2MODN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [N_BIT-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_BIT-1:0] data_out,
  output logic             err,
  output logic             busy
);

  localparam int IW = (EXP_BIT > 1) ? $clog2(EXP_BIT) : 1;
  localparam logic [N_BIT-1:0] N_V  = N_BIT'(N);
  localparam logic [N_BIT-1:0] R1_V = N_BIT'(RMODN);
  localparam logic [N_BIT-1:0] R2_V = N_BIT'(R2MODN);
  localparam logic [N_BIT-1:0] ONE  = N_BIT'(1);

  state_e             state_q, state_d;
  logic [N_BIT-1:0]   a_q, a_d;
  logic               mode_q, mode_d;
  logic [N_BIT-1:0]   x_q, x_d;
  logic [N_BIT-1:0]   am_q, am_d;
  logic [EXP_BIT-1:0] exp_q, exp_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               mm_start_q, mm_start_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [N_BIT-1:0]   data_out_q, data_out_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic [N_BIT-1:0]   mm_x, mm_y, mm_z;
  logic               mm_done;

  // Multiplier operands follow the current step; held stable for the whole op.
  always_comb begin
    mm_x = x_q;
    mm_y = x_q;
    case (state_q)
      ST_TOMONT:   begin mm_x = a_q; mm_y = R2_V; end
      ST_MUL:      mm_y = am_q;
      ST_FROMMONT: mm_y = ONE;
      default:     ;
    endcase
  end

  mont_mul #(.N_BIT(N_BIT), .N(N)) u_mm (
    .clk   (clk),
    .rst   (rst),
    .start (mm_start_q),
    .x     (mm_x),
    .y     (mm_y),
    .done  (mm_done),
    .z     (mm_z)
  );

  // Sequencer: each MM step issues start on entry and advances on done.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    mode_d      = mode_q;
    x_d         = x_q;
    am_d        = am_q;
    exp_d       = exp_q;
    idx_d       = idx_q;
    mm_start_d  = 1'b0;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    err_d       = err_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: if (in_valid && in_ready_q) begin
        a_d        = data_in;
        mode_d     = mode;
        in_ready_d = 1'b0;
        busy_d     = 1'b1;
        state_d    = ST_LOAD;
      end
      ST_LOAD: begin
        x_d        = R1_V;
        exp_d      = mode_q ? EXP_BIT'(D) : EXP_BIT'(E);
        idx_d      = IW'(EXP_BIT - 1);
        // Out-of-range operands never start the multiplier.
        mm_start_d = (a_q < N_V);
        state_d    = ST_TOMONT;
      end
      ST_TOMONT: begin
        if (a_q >= N_V) begin
          data_out_d  = '0;
          err_d       = 1'b1;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else if (mm_done) begin
          am_d       = mm_z;
          mm_start_d = 1'b1;
          state_d    = ST_SQR;
        end
      end
      ST_SQR: if (mm_done) begin
        x_d        = mm_z;
        mm_start_d = 1'b1;
        if (exp_q[idx_q]) begin
          state_d = ST_MUL;
        end else if (idx_q == '0) begin
          state_d = ST_FROMMONT;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = ST_SQR;
        end
      end
      ST_MUL: if (mm_done) begin
        x_d        = mm_z;
        mm_start_d = 1'b1;
        if (idx_q == '0) begin
          state_d = ST_FROMMONT;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = ST_SQR;
        end
      end
      ST_FROMMONT: if (mm_done) begin
        data_out_d  = mm_z;
        err_d       = 1'b0;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register all FSM state and outputs; reset aborts any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      mode_q      <= 1'b0;
      x_q         <= '0;
      am_q        <= '0;
      exp_q       <= '0;
      idx_q       <= '0;
      mm_start_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      mode_q      <= mode_d;
      x_q         <= x_d;
      am_q        <= am_d;
      exp_q       <= exp_d;
      idx_q       <= idx_d;
      mm_start_q  <= mm_start_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule
